disp_scheduler: RTL

DISP_SCHEDULER -- requirements
Module: disp_scheduler

---
 rtl/disp_pkg.sv | 45 ++++
 rtl/disp_scheduler_seg7_decode.sv | 27 ++
 rtl/disp_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit BCD display scheduler: FSM encoding,
// seven-segment codes (active-low, {a..g}) and the BCD increment helper.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Ripple a +1 through four BCD digits; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_scheduler_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; non-BCD blanks.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scheduler.sv
// Start/stop/clear BCD up-counter with a multiplexed 4-digit seven-segment
// scan; one shared decoder is time-shared across the digits.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       running
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic          rst_meta_r, rst_sync_r;
    state_t        state_r, state_nxt_s;
    logic [TW-1:0] div_r, div_nxt_s;
    logic [15:0]   count_r, count_nxt_s;
    logic          tick_s;
    logic [SW-1:0] scan_div_r;
    logic [1:0]    idx_r;
    logic [3:0]    digit_s;
    logic [6:0]    seg_dec_s;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          running_r;

    // Reset assert is immediate; release is retimed through two flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Command decode (clr > stop > start), tick divider and count update
    always_comb begin
        state_nxt_s = state_r;
        div_nxt_s   = div_r;
        count_nxt_s = count_r;
        tick_s      = (state_r == RUN) && (div_r == TICK_LAST);
        if (clr) begin
            state_nxt_s = IDLE;
            div_nxt_s   = '0;
            count_nxt_s = 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        state_nxt_s = RUN;
                        div_nxt_s   = '0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nxt_s = PAUSE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                    if (tick_s) begin
                        div_nxt_s = '0;
                    end else begin
                        div_nxt_s = div_r + TW'(1);
                    end
                    // A tick landing on a stop cycle is dropped
                    if (tick_s && !stop) begin
                        count_nxt_s = bcd_inc(count_r);
                    end else begin
                        count_nxt_s = count_r;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = PAUSE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    div_nxt_s   = '0;
                    count_nxt_s = 16'h0000;
                end
            endcase
        end
    end

    // Control state, divider and count registers
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            state_r   <= IDLE;
            div_r     <= '0;
            count_r   <= 16'h0000;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            div_r     <= div_nxt_s;
            count_r   <= count_nxt_s;
            running_r <= (state_nxt_s == RUN);
        end
    end

    // Free-running digit scan, independent of FSM state
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            scan_div_r <= '0;
            idx_r      <= 2'd0;
        end else if (scan_div_r == SCAN_LAST) begin
            scan_div_r <= '0;
            idx_r      <= idx_r + 2'd1;
        end else begin
            scan_div_r <= scan_div_r + SW'(1);
        end
    end

    // Select the digit currently being scanned
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            2'd0:    digit_s = count_r[3:0];
            2'd1:    digit_s = count_r[7:4];
            2'd2:    digit_s = count_r[11:8];
            2'd3:    digit_s = count_r[15:12];
            default: digit_s = 4'd0;
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd (digit_s),
        .seg (seg_dec_s)
    );

    // Display output registers, one cycle behind index and count
    always_ff @(posedge clk or negedge rst_sync_r) begin
        if (!rst_sync_r) begin
            seg_r <= SEG_BLANK;
            an_r  <= 4'b1111;
        end else begin
            seg_r <= seg_dec_s;
            an_r  <= ~(4'b0001 << idx_r);
        end
    end

    assign seg     = seg_r;
    assign an      = an_r;
    assign running = running_r;

endmodule
